bus_write: RTL and testbench
============================

Name: bus_write

Overview:
- Source-side stage of the shared PE bus.
- Buffers words produced by the local PE (index PE_NO) in a FIFO and requests bus ownership from the central arbiter.
- Once granted, drives words onto the broadcast bus, tagged with PE_NO as the source address.
- Feeds the per-source receive FIFOs of the neighbouring read stages and honours their aggregated full back-pressure.

Parameters:
- DATA_LEN, 16, width of a bus data word
- BUS_ADDR_LEN, 3, width of the source-address tag
- PE_NO, 0, local PE index; driven as addr_to_bus
- FIFO_DEPTH, 8, transmit FIFO depth; power of two, at least 2
- MAX_BURST, 4, maximum words sent per grant; at least 1

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- stall  in  1  PE pipeline stall; blocks acceptance of pe_wr_en
- pe_data_in  in  DATA_LEN  word from PE
- pe_wr_en  in  1  push request from PE
- tx_full  out  1  FIFO full (registered)
- tx_overflow  out  1  sticky: a push was dropped
- dest_full  in  1  OR of all readers' full flags for source PE_NO
- bus_req  out  1  request to arbiter
- bus_grant  in  1  arbiter grant, valid only while bus_req is high
- data_to_bus  out  DATA_LEN  bus data
- addr_to_bus  out  BUS_ADDR_LEN  source tag
- valid_to_bus  out  1  bus word valid

Behaviour:
- Reset (async, rstn=0): FIFO pointers and count 0, state IDLE, burst count 0. Outputs: tx_full=0, tx_overflow=0, bus_req=0, valid_to_bus=0, data_to_bus=0, addr_to_bus=0. Reset mid-burst discards all FIFO contents.
- push = pe_wr_en && ~stall.
  - Push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the word is dropped and tx_overflow sets; it clears only on reset.
- tx_full is registered and equals (count==FIFO_DEPTH) after the update.
- Pointers carry a wrap bit and wrap modulo FIFO_DEPTH.
- A push into an empty FIFO is not poppable in the same cycle; there is no bypass.
- FSM states: IDLE, REQ, XFER, REL.
  - IDLE: goes to REQ when count>0 and ~dest_full.
  - REQ: bus_req=1.
    - If dest_full: go to REL.
    - Else if bus_grant: pop one word, burst=1, go to XFER.
    - Else stay in REQ.
  - XFER: bus_req=1.
    - Pop again if count>0 and ~dest_full and burst<MAX_BURST; increment burst.
    - Otherwise go to REL.
    - Grant is assumed held while bus_req=1. If bus_grant drops in XFER, no pop that cycle; go to REL.
  - REL: bus_req=0 for exactly one cycle, burst cleared, then IDLE.
- bus_req is a registered output: high exactly when the registered state is REQ or XFER.
- Pop timing: on a pop in cycle N, the outputs in cycle N+1 are:
  - data_to_bus = popped word
  - addr_to_bus = PE_NO
  - valid_to_bus = 1
- With no pop, valid_to_bus=0 in cycle N+1 and data_to_bus/addr_to_bus hold their last values.
- Latency: PE push in cycle 0 produces FIFO count 1 in cycle 1, then REQ in cycle 2. With grant in cycle 2, the word is on the bus in cycle 3.
- Back-pressure: dest_full is sampled each cycle before a pop; a pop never occurs in a cycle where dest_full=1.
- Simultaneous push+pop leaves count unchanged.
- stall does not affect the bus-side FSM.

Test Plan:
- Single word: after reset, push 0x1234 with grant always high → bus_req high at cycle 2; at cycle 3 data_to_bus=0x1234, addr_to_bus=PE_NO, valid_to_bus=1 for one cycle; REL then IDLE.
- Burst limit: push 6 words with MAX_BURST=4 and grant held → 4 consecutive valid words, bus_req low for 1 cycle, new request, remaining 2 words delivered in order.
- Back-pressure: raise dest_full mid-burst after 2 words → no further valid_to_bus while high; FSM goes to REL/IDLE; transfer resumes after dest_full drops, with no loss or duplication.
- Full/overflow: with grant held low, push 9 words into FIFO_DEPTH=8 → tx_full=1 after the 8th; 9th dropped; tx_overflow=1; later drain shows exactly words 1–8.
- Push+pop on full, and stall: push while full in a pop cycle is accepted and count stays 8; pe_wr_en while stall=1 → word ignored, count unchanged.
- Reset mid-burst: assert rstn=0 during XFER → outputs immediately 0 and FIFO empty; no valid_to_bus after release until a new push.

Source files
------------

// File: rtl/bus_write_if.sv
// bus_write_if: PE-side push port and broadcast-bus signals of one bus_write source stage
interface bus_write_if #(
  parameter int DATA_LEN     = 16,
  parameter int BUS_ADDR_LEN = 3
);
  logic                    stall;
  logic [DATA_LEN-1:0]     pe_data_in;
  logic                    pe_wr_en;
  logic                    tx_full;
  logic                    tx_overflow;
  logic                    dest_full;
  logic                    bus_req;
  logic                    bus_grant;
  logic [DATA_LEN-1:0]     data_to_bus;
  logic [BUS_ADDR_LEN-1:0] addr_to_bus;
  logic                    valid_to_bus;

  modport master (
    input  stall, pe_data_in, pe_wr_en, dest_full, bus_grant,
    output tx_full, tx_overflow, bus_req, data_to_bus, addr_to_bus, valid_to_bus
  );

  modport slave (
    output stall, pe_data_in, pe_wr_en, dest_full, bus_grant,
    input  tx_full, tx_overflow, bus_req, data_to_bus, addr_to_bus, valid_to_bus
  );
endinterface

// File: rtl/bus_write.sv
// bus_write: buffers local PE words and bursts them onto the shared bus tagged with PE_NO
module bus_write #(
  parameter int DATA_LEN     = 16,
  parameter int BUS_ADDR_LEN = 3,
  parameter int PE_NO        = 0,
  parameter int FIFO_DEPTH   = 8,
  parameter int MAX_BURST    = 4
) (
  input logic       clk,
  input logic       rstn,
  bus_write_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [AW:0]   DEPTH = (AW + 1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] BMAX  = BW'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, REQ, XFER, REL} state_t;

  state_t              state;
  logic [DATA_LEN-1:0] mem [FIFO_DEPTH];
  logic [AW:0]         wr_ptr, rd_ptr, count, count_nx;
  logic [BW-1:0]       burst;
  logic                push, push_ok, pop, has_data;

  // A freshly pushed word only becomes visible through count next cycle, so there is no bypass path.
  always_comb begin
    push     = bus.pe_wr_en && !bus.stall;
    has_data = count != '0;
    pop      = bus.bus_grant && !bus.dest_full && has_data &&
               (state == REQ || (state == XFER && burst < BMAX));
    push_ok  = push && (count < DEPTH || pop);
    count_nx = count + (AW + 1)'(push_ok) - (AW + 1)'(pop);
  end

  // Storage array needs no reset; the pointers decide what is valid.
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr[AW-1:0]] <= bus.pe_data_in;

  // Pointers carry a wrap bit and roll over naturally since the depth is a power of two.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      bus.tx_full     <= 1'b0;
      bus.tx_overflow <= 1'b0;
    end else begin
      wr_ptr          <= wr_ptr + (AW + 1)'(push_ok);
      rd_ptr          <= rd_ptr + (AW + 1)'(pop);
      count           <= count_nx;
      bus.tx_full     <= count_nx == DEPTH;
      bus.tx_overflow <= bus.tx_overflow | (push && !push_ok);
    end

  // Arbitration FSM; bus_req is registered alongside the state it mirrors.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state       <= IDLE;
      burst       <= '0;
      bus.bus_req <= 1'b0;
    end else
      case (state)
        IDLE:
          if (has_data && !bus.dest_full) begin
            state       <= REQ;
            bus.bus_req <= 1'b1;
          end
        REQ:
          if (bus.dest_full) begin
            state       <= REL;
            bus.bus_req <= 1'b0;
          end else if (bus.bus_grant) begin
            state <= XFER;
            burst <= BW'(1);
          end
        XFER:
          if (pop) burst <= burst + BW'(1);
          else begin
            state       <= REL;
            bus.bus_req <= 1'b0;
          end
        default: begin
          state <= IDLE;
          burst <= '0;
        end
      endcase

  // Popped word appears on the bus the cycle after the pop; data/addr hold otherwise.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      bus.valid_to_bus <= 1'b0;
      bus.data_to_bus  <= '0;
      bus.addr_to_bus  <= '0;
    end else begin
      bus.valid_to_bus <= pop;
      if (pop) begin
        bus.data_to_bus <= mem[rd_ptr[AW-1:0]];
        bus.addr_to_bus <= BUS_ADDR_LEN'(PE_NO);
      end
    end
endmodule

// File: tb/tb_bus_write.sv
// tb_bus_write: directed vector table plus hand sequences for overflow, stall and reset corners
module tb_bus_write;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  bus_write_if #(.DATA_LEN(16), .BUS_ADDR_LEN(3)) bif ();

  bus_write #(
    .DATA_LEN(16), .BUS_ADDR_LEN(3), .PE_NO(5), .FIFO_DEPTH(8), .MAX_BURST(4)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bif)
  );

  typedef struct {
    logic        wr;
    logic [15:0] din;
    logic        dfull;
    logic        e_req;
    logic        e_valid;
    logic [15:0] e_data;
  } vec_t;

  vec_t        tv[$];
  logic [15:0] got[$];
  logic [15:0] exp_words[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic add(input logic wr, input logic [15:0] din, input logic dfull,
                     input logic e_req, input logic e_valid, input logic [15:0] e_data);
    vec_t v;
    v.wr = wr; v.din = din; v.dfull = dfull;
    v.e_req = e_req; v.e_valid = e_valid; v.e_data = e_data;
    tv.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [15:0] din);
    bif.pe_wr_en   = wr;
    bif.pe_data_in = din;
  endtask

  initial begin
    bif.stall = 0; bif.pe_wr_en = 0; bif.pe_data_in = '0; bif.dest_full = 0; bif.bus_grant = 1;
    // single word: push cycle 0, request cycle 2, on bus cycle 3, REL then IDLE
    add(1, 16'h1234, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 1, 16'h1234);
    add(0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    // six words, burst capped at four, then re-request for the last two
    add(1, 16'hA001, 0, 0, 0, 0);
    add(1, 16'hA002, 0, 0, 0, 0);
    add(1, 16'hA003, 0, 1, 0, 0);
    add(1, 16'hA004, 0, 1, 1, 16'hA001);
    add(1, 16'hA005, 0, 1, 1, 16'hA002);
    add(1, 16'hA006, 0, 1, 1, 16'hA003);
    add(0, 0, 0, 1, 1, 16'hA004);
    add(0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 1, 16'hA005);
    add(0, 0, 0, 1, 1, 16'hA006);
    add(0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    // dest_full rises after two words, transfer resumes once it drops
    add(1, 16'hD001, 0, 0, 0, 0);
    add(1, 16'hD002, 0, 0, 0, 0);
    add(1, 16'hD003, 0, 1, 0, 0);
    add(1, 16'hD004, 0, 1, 1, 16'hD001);
    add(0, 0, 1, 1, 1, 16'hD002);
    add(0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 1, 16'hD003);
    add(0, 0, 0, 1, 1, 16'hD004);
    add(0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);

    #12;
    chk("rst_req", bif.bus_req, 0);
    chk("rst_valid", bif.valid_to_bus, 0);
    chk("rst_data", bif.data_to_bus, 0);
    chk("rst_addr", bif.addr_to_bus, 0);
    chk("rst_full", bif.tx_full, 0);
    chk("rst_ovf", bif.tx_overflow, 0);
    @(negedge clk);
    rstn = 1;

    foreach (tv[i]) begin
      step();
      chk($sformatf("vec%0d_req", i), bif.bus_req, tv[i].e_req);
      chk($sformatf("vec%0d_valid", i), bif.valid_to_bus, tv[i].e_valid);
      if (tv[i].e_valid) begin
        chk($sformatf("vec%0d_data", i), bif.data_to_bus, tv[i].e_data);
        chk($sformatf("vec%0d_addr", i), bif.addr_to_bus, 5);
      end
      drive(tv[i].wr, tv[i].din);
      bif.dest_full = tv[i].dfull;
    end
    step();
    drive(0, 0);
    bif.dest_full = 0;

    // fill with grant low; a stalled push in the middle must be ignored
    bif.bus_grant = 0;
    for (int i = 1; i <= 7; i++) begin
      drive(1, 16'h0100 + 16'(i));
      step();
      chk($sformatf("fill%0d_full", i), bif.tx_full, 0);
    end
    bif.stall = 1;
    drive(1, 16'hDEAD);
    step();
    chk("stall_full", bif.tx_full, 0);
    bif.stall = 0;
    drive(1, 16'h0108);
    step();
    chk("w8_full", bif.tx_full, 1);
    chk("w8_ovf", bif.tx_overflow, 0);
    drive(1, 16'h0109);
    step();
    chk("w9_full", bif.tx_full, 1);
    chk("w9_ovf", bif.tx_overflow, 1);
    chk("w9_req", bif.bus_req, 1);
    chk("w9_valid", bif.valid_to_bus, 0);
    // push while full in the very cycle the first pop happens
    bif.bus_grant = 1;
    drive(1, 16'h010A);
    step();
    drive(0, 0);
    chk("pp_full", bif.tx_full, 1);
    chk("pp_valid", bif.valid_to_bus, 1);
    if (bif.valid_to_bus) got.push_back(bif.data_to_bus);
    for (int i = 0; i < 80 && got.size() < 12; i++) begin
      step();
      if (bif.valid_to_bus) got.push_back(bif.data_to_bus);
    end
    for (int i = 1; i <= 8; i++) exp_words.push_back(16'h0100 + 16'(i));
    exp_words.push_back(16'h010A);
    chk("drain_count", got.size(), exp_words.size());
    foreach (exp_words[i])
      chk($sformatf("drain%0d", i), (i < got.size()) ? got[i] : 16'hXXXX, exp_words[i]);
    chk("drain_full", bif.tx_full, 0);
    chk("drain_ovf_sticky", bif.tx_overflow, 1);

    // reset in the middle of a burst
    drive(1, 16'hB001);
    step();
    drive(1, 16'hB002);
    step();
    drive(1, 16'hB003);
    step();
    drive(0, 0);
    chk("mid_valid", bif.valid_to_bus, 1);
    chk("mid_data", bif.data_to_bus, 16'hB001);
    #2 rstn = 0;
    #1;
    chk("ar_req", bif.bus_req, 0);
    chk("ar_valid", bif.valid_to_bus, 0);
    chk("ar_data", bif.data_to_bus, 0);
    chk("ar_addr", bif.addr_to_bus, 0);
    chk("ar_full", bif.tx_full, 0);
    chk("ar_ovf", bif.tx_overflow, 0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("post_rst%0d_valid", i), bif.valid_to_bus, 0);
      chk($sformatf("post_rst%0d_req", i), bif.bus_req, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
